// File: rtl/serial_frame_sink.sv
// rtl/serial_frame_sink.sv - sen/sd frame deserializer writing each frame bit-by-bit into RB2
// Define S2_VERIFY_EN to add a read-back verify pass after every frame write.
module serial_frame_sink #(
  parameter int FA_W   = 3,
  parameter int DATA_W = 18,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [MEM_AW-1:0] RB2_A,
  output logic              RB2_D,
  input  logic              RB2_Q,
  output logic              done,
  output logic              err
);
  localparam int FRAME_W = FA_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int K_W     = $clog2(DATA_W + 1);
  localparam int NFA     = 1 << FA_W;
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_W + 1);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(DATA_W);

  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_VERIFY} w_state_t;

  rx_state_t          rx_state;
  w_state_t           w_state;
  logic [FRAME_W-1:0] shifter;
  logic [CNT_W-1:0]   cnt;
  logic [FA_W-1:0]    w_fa;
  logic [DATA_W-1:0]  w_sh;
  logic [MEM_AW-1:0]  w_addr;
  logic [K_W-1:0]     w_k;
  logic [NFA-1:0]     mask;
`ifdef S2_VERIFY_EN
  logic [DATA_W-1:0]  w_data;
  logic [MEM_AW-1:0]  w_base;
`else
  logic               unused_q;
  assign unused_q = RB2_Q;
`endif

  logic              frame_end;
  logic              commit;
  logic [FA_W-1:0]   rx_fa;
  logic [MEM_AW-1:0] rx_base;
  logic [NFA-1:0]    mask_next;

  always_comb begin
    frame_end = (rx_state == RX_SHIFT) && sen;
    commit    = frame_end && (cnt == CNT_FRAME);
    rx_fa     = shifter[FRAME_W-1 -: FA_W];
    // fa*DATA_W as a shift-add over the address bits
    rx_base   = '0;
    for (int i = 0; i < FA_W; i++)
      if (rx_fa[i]) rx_base = rx_base + MEM_AW'(DATA_W << i);
    mask_next = mask | (NFA'(1) << w_fa);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      w_state  <= W_IDLE;
      shifter  <= '0;
      cnt      <= '0;
      w_fa     <= '0;
      w_sh     <= '0;
      w_addr   <= '0;
      w_k      <= '0;
      mask     <= '0;
`ifdef S2_VERIFY_EN
      w_data   <= '0;
      w_base   <= '0;
`endif
      RB2_RW   <= 1'b1;
      RB2_A    <= '0;
      RB2_D    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE:
          if (!sen) begin
            shifter  <= {shifter[FRAME_W-2:0], sd};
            cnt      <= CNT_W'(1);
            rx_state <= RX_SHIFT;
          end
        RX_SHIFT:
          if (!sen) begin
            shifter <= {shifter[FRAME_W-2:0], sd};
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          end else begin
            rx_state <= RX_IDLE;
          end
        default: rx_state <= RX_IDLE;
      endcase

      // short/long frame, or a good frame arriving while the writer is busy
      if (frame_end && (cnt != CNT_FRAME)) err <= 1'b1;
      if (commit && (w_state != W_IDLE))   err <= 1'b1;

      case (w_state)
        W_IDLE:
          if (commit) begin
            w_state <= W_WRITE;
            w_fa    <= rx_fa;
            w_sh    <= shifter[DATA_W-1:0];
            w_addr  <= rx_base;
            w_k     <= '0;
`ifdef S2_VERIFY_EN
            w_data  <= shifter[DATA_W-1:0];
            w_base  <= rx_base;
`endif
          end
        W_WRITE:
          if (w_k != K_LAST) begin
            RB2_RW <= 1'b0;
            RB2_A  <= w_addr;
            RB2_D  <= w_sh[DATA_W-1];
            w_sh   <= w_sh << 1;
            w_addr <= w_addr + 1'b1;
            w_k    <= w_k + 1'b1;
          end else begin
            RB2_RW <= 1'b1;
`ifdef S2_VERIFY_EN
            w_state <= W_VERIFY;
            RB2_A   <= w_base;
            w_addr  <= w_base + 1'b1;
            w_sh    <= w_data;
            w_k     <= K_W'(1);
`else
            w_state <= W_IDLE;
            mask    <= mask_next;
            done    <= done | (&mask_next);
`endif
          end
`ifdef S2_VERIFY_EN
        W_VERIFY: begin
          // RB2_Q reflects the address presented during the previous cycle
          if (RB2_Q != w_sh[DATA_W-1]) err <= 1'b1;
          w_sh <= w_sh << 1;
          if (w_k != K_LAST) begin
            RB2_A  <= w_addr;
            w_addr <= w_addr + 1'b1;
            w_k    <= w_k + 1'b1;
          end else begin
            w_state <= W_IDLE;
            mask    <= mask_next;
            done    <= done | (&mask_next);
          end
        end
`endif
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_frame_sink.sv
// tb/tb_serial_frame_sink.sv - randomized frame stimulus checked cycle-by-cycle against a frame-level model
module tb_serial_frame_sink;
  localparam int FA_W   = 3;
  localparam int DATA_W = 18;
  localparam int MEM_AW = 8;
  localparam int FRAME  = FA_W + DATA_W;
  localparam int NMAX   = 4096;
`ifdef S2_VERIFY_EN
  localparam int BUSY = 2 * DATA_W + 1;
`else
  localparam int BUSY = DATA_W + 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sen = 1'b1;
  logic              sd  = 1'b0;
  logic              RB2_RW;
  logic [MEM_AW-1:0] RB2_A;
  logic              RB2_D;
  logic              RB2_Q;
  logic              done;
  logic              err;
  logic              rb2_mem [0:(1<<MEM_AW)-1];

  bit rst_v [NMAX];
  bit sen_v [NMAX];
  bit sd_v  [NMAX];
  bit exp_rw   [NMAX];
  bit exp_d    [NMAX];
  bit exp_err  [NMAX];
  bit exp_done [NMAX];
  int exp_a    [NMAX];
  int n_cyc;
  int cur_cyc;
  int n_total;
  int n_pass;

  always #5 clk = ~clk;

  serial_frame_sink #(.FA_W(FA_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst), .sen(sen), .sd(sd),
    .RB2_RW(RB2_RW), .RB2_A(RB2_A), .RB2_D(RB2_D), .RB2_Q(RB2_Q),
    .done(done), .err(err)
  );

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < (1 << MEM_AW); i++) rb2_mem[i] <= 1'b0;
    end else if (!RB2_RW) begin
      rb2_mem[RB2_A] <= RB2_D;
    end
  end
  assign RB2_Q = rb2_mem[RB2_A];

  task automatic chk(input string tag, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cur_cyc, got, want);
  endtask

  task automatic put(input bit r, input bit s, input bit d);
    rst_v[n_cyc] = r;
    sen_v[n_cyc] = s;
    sd_v[n_cyc]  = d;
    n_cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b1, 1'b1, 1'b0);
  endtask

  task automatic frame(input int fa, input int data, input int len);
    logic [FA_W-1:0]   f;
    logic [DATA_W-1:0] dv;
    logic [FRAME-1:0]  w;
    bit b;
    f  = fa[FA_W-1:0];
    dv = data[DATA_W-1:0];
    w  = {f, dv};
    for (int i = 0; i < len; i++) begin
      b = (i < FRAME) ? w[FRAME-1-i] : bit'($urandom % 2);
      put(1'b1, 1'b0, b);
    end
  endtask

  // Frame-level model: a frame is a run of sen=0 edges ending at the first sen=1 edge E.
  task automatic build_model();
    int run, last_commit, pend_edge, pend_fa, fa;
    bit pend, e, dn;
    bit [7:0] mask;
    logic [FRAME-1:0] bits;
    run = 0; last_commit = -100000; pend = 0; pend_edge = 0; pend_fa = 0;
    mask = '0; e = 0; dn = 0; bits = '0;
    for (int n = 0; n < n_cyc; n++) begin
      exp_rw[n] = 1'b1; exp_a[n] = 0; exp_d[n] = 1'b0;
    end
    for (int n = 0; n < n_cyc; n++) begin
      if (!rst_v[n]) begin
        run = 0; last_commit = -100000; pend = 0; mask = '0; e = 0; dn = 0;
        for (int m = n; m < n_cyc; m++) exp_rw[m] = 1'b1;
      end else begin
        if (!sen_v[n]) begin
          if (run < FRAME) bits[FRAME-1-run] = sd_v[n];
          run++;
        end else if (run > 0) begin
          if (run != FRAME || n <= last_commit + BUSY) begin
            e = 1'b1;
          end else begin
            fa = int'(bits[FRAME-1 -: FA_W]);
            last_commit = n; pend = 1'b1; pend_edge = n + BUSY; pend_fa = fa;
            for (int k = 0; k < DATA_W; k++) begin
              if (n + 1 + k < n_cyc) begin
                exp_rw[n+1+k] = 1'b0;
                exp_a[n+1+k]  = fa * DATA_W + k;
                exp_d[n+1+k]  = bits[DATA_W-1-k];
              end
            end
          end
          run = 0;
        end
        if (pend && n == pend_edge) begin
          mask[pend_fa] = 1'b1;
          pend = 1'b0;
          if (mask == 8'hFF) dn = 1'b1;
        end
      end
      exp_err[n]  = e;
      exp_done[n] = dn;
    end
  endtask

  initial begin
    int e_idx;
    n_cyc = 0; n_total = 0; n_pass = 0; cur_cyc = 0;

    put(1'b0, 1'b1, 1'b0); put(1'b0, 1'b1, 1'b0); idle(3);
    frame(5, 'h2A5C3, 21); idle(25);
    for (int fa = 0; fa < 8; fa++) begin frame(fa, int'($urandom), 21); idle(20); end
    frame(2, int'($urandom), 15); idle(5);
    frame(3, int'($urandom), 21); idle(25);
    frame(4, int'($urandom), 25); idle(25);
    frame(6, int'($urandom), 21); idle(2);
    frame(1, int'($urandom), 21); idle(45);

    put(1'b0, 1'b1, 1'b0); put(1'b0, 1'b1, 1'b0); idle(3);
    for (int fa = 0; fa < 7; fa++) begin frame(fa, int'($urandom), 21); idle(20); end
    frame(7, int'($urandom), 21);
    e_idx = n_cyc;
    idle(30);
    rst_v[e_idx+6] = 1'b0;
    frame(7, int'($urandom), 21); idle(25);

    put(1'b0, 1'b1, 1'b0); put(1'b0, 1'b1, 1'b0); idle(3);
    for (int i = 0; i < 20; i++) begin
      frame(int'($urandom_range(0, 7)), int'($urandom), int'($urandom_range(19, 23)));
      idle(int'($urandom_range(1, 40)));
    end
    idle(45);

    build_model();

    for (int n = 0; n < n_cyc; n++) begin
      rst = rst_v[n]; sen = sen_v[n]; sd = sd_v[n];
      @(posedge clk);
      @(negedge clk);
      cur_cyc = n;
      if (n == 1) begin
        chk("reset_addr", int'(RB2_A), 0);
        chk("reset_data", int'(RB2_D), 0);
      end
      chk("rw", int'(RB2_RW), int'(exp_rw[n]));
      if (!exp_rw[n]) begin
        chk("addr", int'(RB2_A), exp_a[n]);
        chk("data", int'(RB2_D), int'(exp_d[n]));
      end
      chk("err", int'(err), int'(exp_err[n]));
      chk("done", int'(done), int'(exp_done[n]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
